// File: rtl/fp32_to_fixed_unpacker.sv
// IEEE-754 single to signed Q2.30 converter at the CORDIC input, one registered stage.
// Build macro UNPACKER_ROUND_EN: round half-up on right shifts instead of truncating toward zero.
module fp32_to_fixed_unpacker #(
    parameter logic [31:0] RANGE_LIMIT = 32'h40000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] data,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        is_special,
    output logic        out_of_range
);

    // Exponent at which the 24-bit mantissa lands unshifted on the Q2.30 grid.
    localparam logic [7:0] EXP_UNITY = 8'd120;
    localparam logic [7:0] EXP_ONE   = 8'd127;
    localparam logic [7:0] EXP_SAT   = 8'd128;

    logic        sign_s;
    logic [7:0]  exp_s;
    logic [22:0] frac_s;
    logic [23:0] mant_s;
    logic [7:0]  lsh_s;
    logic [7:0]  rsh_s;
    logic [31:0] mag_s;
    logic        sat_s;
    logic        special_s;
    logic [31:0] conv_res_s;
    logic        conv_oor_s;

    logic        out_valid_d;
    logic        out_valid_q;
    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        is_special_d;
    logic        is_special_q;
    logic        out_of_range_d;
    logic        out_of_range_q;

    // Split the operand into its fields and restore the hidden one.
    always_comb begin
        sign_s = data[31];
        exp_s  = data[30:23];
        frac_s = data[22:0];
        mant_s = {1'b1, frac_s};
        lsh_s  = exp_s - EXP_UNITY;
        rsh_s  = EXP_UNITY - exp_s;
    end

`ifdef UNPACKER_ROUND_EN
    // e==96 still rounds up to the LSB because its first dropped bit is the hidden one.
    localparam logic [7:0] EXP_MIN_SHIFT = 8'd96;

    logic [32:0] ext_s;

    // Magnitude shifter with one guard bit kept for half-up rounding.
    always_comb begin
        ext_s = 33'd0;
        mag_s = 32'd0;
        if (exp_s >= EXP_SAT) begin
            mag_s = 32'd0;
        end else if (exp_s >= EXP_UNITY) begin
            mag_s = {8'd0, mant_s} << lsh_s;
        end else if (exp_s >= EXP_MIN_SHIFT) begin
            ext_s = {8'd0, mant_s, 1'b0} >> rsh_s;
            mag_s = ext_s[32:1] + {31'd0, ext_s[0]};
        end else begin
            mag_s = 32'd0;
        end
    end
`else
    localparam logic [7:0] EXP_MIN_SHIFT = 8'd97;

    // Magnitude shifter, truncating toward zero.
    always_comb begin
        mag_s = 32'd0;
        if (exp_s >= EXP_SAT) begin
            mag_s = 32'd0;
        end else if (exp_s >= EXP_UNITY) begin
            mag_s = {8'd0, mant_s} << lsh_s;
        end else if (exp_s >= EXP_MIN_SHIFT) begin
            mag_s = {8'd0, mant_s} >> rsh_s;
        end else begin
            mag_s = 32'd0;
        end
    end
`endif

    // Sign application, saturation and flags; a zero magnitude never yields negative zero.
    always_comb begin
        sat_s      = (exp_s >= EXP_SAT);
        special_s  = (exp_s == EXP_ONE) && (frac_s == 23'd0);
        conv_res_s = 32'd0;
        conv_oor_s = 1'b0;
        if (sat_s) begin
            conv_res_s = sign_s ? 32'h80000000 : 32'h7FFFFFFF;
            conv_oor_s = 1'b1;
        end else begin
            conv_res_s = sign_s ? (32'd0 - mag_s) : mag_s;
            conv_oor_s = (mag_s > RANGE_LIMIT);
        end
    end

    // Capture on a valid beat, otherwise hold everything except out_valid.
    always_comb begin
        out_valid_d    = in_valid;
        result_d       = result_q;
        is_special_d   = is_special_q;
        out_of_range_d = out_of_range_q;
        if (in_valid) begin
            result_d       = conv_res_s;
            is_special_d   = special_s;
            out_of_range_d = conv_oor_s;
        end else begin
            result_d       = result_q;
            is_special_d   = is_special_q;
            out_of_range_d = out_of_range_q;
        end
    end

    // Output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            result_q       <= 32'd0;
            is_special_q   <= 1'b0;
            out_of_range_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            result_q       <= result_d;
            is_special_q   <= is_special_d;
            out_of_range_q <= out_of_range_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign result       = result_q;
    assign is_special   = is_special_q;
    assign out_of_range = out_of_range_q;

endmodule

// File: tb/tb_fp32_to_fixed_unpacker.sv
// Scoreboard bench for fp32_to_fixed_unpacker: directed vectors, random stream, hold and reset.
module tb_fp32_to_fixed_unpacker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] data = 32'd0;
    logic        out_valid;
    logic [31:0] result;
    logic        is_special;
    logic        out_of_range;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        sp;
        logic        oor;
    } exp_t;

    exp_t sb[$];

    fp32_to_fixed_unpacker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .data        (data),
        .out_valid   (out_valid),
        .result      (result),
        .is_special  (is_special),
        .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    // Reference model in real arithmetic: value * 2^30, then truncate (or round) and sign.
    function automatic exp_t model(input logic [31:0] d);
        exp_t        e;
        int          ex;
        real         m;
        real         mag_r;
        longint      mag;
        logic [31:0] t;
        ex   = int'(d[30:23]);
        e.sp = (ex == 127) && (d[22:0] == 23'd0);
        if (ex >= 128) begin
            e.r   = d[31] ? 32'h80000000 : 32'h7FFFFFFF;
            e.oor = 1'b1;
        end else begin
            if (ex == 0) begin
                mag = 64'sd0;
            end else begin
                m     = real'(int'({1'b1, d[22:0]}));
                mag_r = m * (2.0 ** real'(ex - 120));
`ifdef UNPACKER_ROUND_EN
                mag_r = mag_r + 0.5;
`endif
                mag = longint'($floor(mag_r));
            end
            t     = mag[31:0];
            e.oor = (mag > 64'sh40000000);
            e.r   = d[31] ? (32'd0 - t) : t;
        end
        return e;
    endfunction

    task automatic drive(input logic [31:0] d, input exp_t e);
        in_valid = 1'b1;
        data     = d;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_operand();
        logic [7:0]  ex;
        logic [22:0] fr;
        int          sel;
        sel = int'($urandom_range(0, 19));
        if (sel == 0)      ex = 8'd0;
        else if (sel == 1) ex = 8'd255;
        else               ex = 8'($urandom_range(94, 130));
        fr = 23'($urandom);
        return {1'($urandom), ex, fr};
    endfunction

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data     = 32'h3F800000;
        repeat (2) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        n_checks++;
        if ({is_special, out_of_range} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got sp=%b oor=%b expected 0 0", is_special, out_of_range);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_spec_vectors();
        logic [31:0] vin[$];
        exp_t        vexp[$];
        exp_t        e;
        vin = '{32'h3F800000, 32'hBF800000, 32'h30800000, 32'h00000000, 32'h80000000,
                32'h350637BD, 32'h3F000000, 32'h3F47AE14, 32'h40000000, 32'hFF800000,
                32'h7FC00000, 32'h3FC00000, 32'hBFC00000, 32'h3FFFFFFF, 32'h00400000,
                32'h807FFFFF, 32'h30000000};
        vexp = '{{32'h40000000, 1'b1, 1'b0}, {32'hC0000000, 1'b1, 1'b0},
                 {32'h00000001, 1'b0, 1'b0}, {32'h00000000, 1'b0, 1'b0},
                 {32'h00000000, 1'b0, 1'b0},
`ifdef UNPACKER_ROUND_EN
                 {32'h00000219, 1'b0, 1'b0},
`else
                 {32'h00000218, 1'b0, 1'b0},
`endif
                 {32'h20000000, 1'b0, 1'b0}, {32'h31EB8500, 1'b0, 1'b0},
                 {32'h7FFFFFFF, 1'b0, 1'b1}, {32'h80000000, 1'b0, 1'b1},
                 {32'h7FFFFFFF, 1'b0, 1'b1}, {32'h60000000, 1'b0, 1'b1},
                 {32'hA0000000, 1'b0, 1'b1}, {32'h7FFFFF80, 1'b0, 1'b1},
                 {32'h00000000, 1'b0, 1'b0}, {32'h00000000, 1'b0, 1'b0},
`ifdef UNPACKER_ROUND_EN
                 {32'h00000001, 1'b0, 1'b0}};
`else
                 {32'h00000000, 1'b0, 1'b0}};
`endif
        for (int i = 0; i <= vin.size(); i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || result !== e.r || is_special !== e.sp || out_of_range !== e.oor) begin
                    n_fail++;
                    $display("FAIL spec_vec[%0d]: got v=%b r=%h sp=%b oor=%b expected v=1 r=%h sp=%b oor=%b",
                             i - 1, out_valid, result, is_special, out_of_range, e.r, e.sp, e.oor);
                end
            end
            if (i < vin.size()) drive(vin[i], vexp[i]);
            else in_valid = 1'b0;
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        drive(32'h3F000000, '{32'h20000000, 1'b0, 1'b0});
        @(negedge clk);
        void'(sb.pop_front());
        in_valid = 1'b0;
        data     = 32'hC0000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || result !== 32'h20000000 || is_special !== 1'b0 || out_of_range !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: got v=%b r=%h sp=%b oor=%b expected v=0 r=20000000 sp=0 oor=0",
                         i, out_valid, result, is_special, out_of_range);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || result !== e.r || is_special !== e.sp || out_of_range !== e.oor) begin
                    n_fail++;
                    $display("FAIL b2b[%0d]: got v=%b r=%h sp=%b oor=%b expected v=1 r=%h sp=%b oor=%b",
                             i - 1, out_valid, result, is_special, out_of_range, e.r, e.sp, e.oor);
                end
            end
            if (i < 300) begin
                d = rand_operand();
                drive(d, model(d));
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_midstream_reset();
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (out_valid !== 1'b1 || result !== e.r || is_special !== e.sp || out_of_range !== e.oor) begin
                    n_fail++;
                    $display("FAIL mid_stream[%0d]: got v=%b r=%h sp=%b oor=%b expected v=1 r=%h sp=%b oor=%b",
                             i - 1, out_valid, result, is_special, out_of_range, e.r, e.sp, e.oor);
                end
            end
            d = (i == 3) ? 32'hBF800000 : rand_operand();
            drive(d, model(d));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || is_special !== 1'b0 || out_of_range !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b r=%h sp=%b oor=%b expected all 0",
                     out_valid, result, is_special, out_of_range);
        end
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held: got v=%b r=%h expected v=0 r=00000000", out_valid, result);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_spec_vectors();
        test_hold();
        test_back_to_back();
        test_midstream_reset();
        test_spec_vectors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
